// File: rtl/dvp_pkg.sv
// Shared DVP definitions: frame FSM encoding, byte order and counter sizing helpers.
// The DVP RX state machine uses the same state encoding.
package dvp_pkg;

    typedef enum logic [2:0] {
        IDLE_ST,
        VSYNC_ST,
        VBP_ST,
        ACT_ST,
        HBLK_ST,
        VFP_ST
    } dvp_state_t;

    localparam bit HI_BYTE_FIRST = 1'b1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dvp_tx_controller_if.sv
// Pixel handshake plus DVP output bus of the transmitter.
// master: the transmitter (pixel sink, bus driver); slave: source / bus observer.
interface dvp_tx_controller_if #(
    parameter int DVP_DATA_W = 8,
    parameter int RGB_PXL_W  = 16
);
    logic [RGB_PXL_W-1:0]  rgb_pxl;
    logic                  rgb_pxl_vld;
    logic                  rgb_pxl_rdy;
    logic                  dvp_vsync;
    logic                  dvp_href;
    logic [DVP_DATA_W-1:0] dvp_data;

    modport master (
        input  rgb_pxl, rgb_pxl_vld,
        output rgb_pxl_rdy, dvp_vsync, dvp_href, dvp_data
    );

    modport slave (
        output rgb_pxl, rgb_pxl_vld,
        input  rgb_pxl_rdy, dvp_vsync, dvp_href, dvp_data
    );
endinterface

// File: rtl/dvp_tx_timing_gen.sv
// Free-running DVP frame timing: FSM with column, line and cycle counters.
// Reports the current state, the byte phase within ACT_ST and the last cycle of a frame.
module dvp_tx_timing_gen
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 144,
    parameter int VSYNC_W  = 3,
    parameter int V_BP     = 17,
    parameter int V_FP     = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cam_start,
    output dvp_state_t state,
    output logic       phase,
    output logic       frame_end
);
    localparam int LINE_P = 2 * H_ACTIVE + H_BLANK;
    localparam int COL_W  = cnt_w(2 * H_ACTIVE);
    localparam int LINE_W = cnt_w(max2(V_ACTIVE, V_BP));
    localparam int CYC_W  = cnt_w(max2(max2(VSYNC_W, H_BLANK), max2(V_FP, LINE_P)));

    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(2 * H_ACTIVE - 1);
    localparam logic [LINE_W-1:0] ACT_LAST   = LINE_W'(V_ACTIVE - 1);
    localparam logic [LINE_W-1:0] VBP_LAST   = LINE_W'(V_BP - 1);
    localparam logic [CYC_W-1:0]  VSYNC_LAST = CYC_W'(VSYNC_W - 1);
    localparam logic [CYC_W-1:0]  LINE_LAST  = CYC_W'(LINE_P - 1);
    localparam logic [CYC_W-1:0]  HBLK_LAST  = CYC_W'(H_BLANK - 1);
    localparam logic [CYC_W-1:0]  VFP_LAST   = CYC_W'(V_FP - 1);

    dvp_state_t        state_reg, state_next;
    logic [COL_W-1:0]  col_reg, col_next;
    logic [LINE_W-1:0] line_reg, line_next;
    logic [CYC_W-1:0]  cyc_reg, cyc_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE_ST;
            col_reg   <= '0;
            line_reg  <= '0;
            cyc_reg   <= '0;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            line_reg  <= line_next;
            cyc_reg   <= cyc_next;
        end
    end

    // Column and cycle counters restart on every state change; the line count
    // spans the ACT/HBLK pairs of one frame region.
    always_comb begin
        state_next = state_reg;
        col_next   = '0;
        line_next  = line_reg;
        cyc_next   = cyc_reg + CYC_W'(1);
        case (state_reg)
            IDLE_ST: begin
                cyc_next = '0;
                if (cam_start) state_next = VSYNC_ST;
            end
            VSYNC_ST: begin
                if (cyc_reg == VSYNC_LAST) begin
                    cyc_next   = '0;
                    line_next  = '0;
                    state_next = (V_BP == 0) ? ACT_ST : VBP_ST;
                end
            end
            VBP_ST: begin
                if (cyc_reg == LINE_LAST) begin
                    cyc_next = '0;
                    if (line_reg == VBP_LAST) begin
                        line_next  = '0;
                        state_next = ACT_ST;
                    end else begin
                        line_next = line_reg + LINE_W'(1);
                    end
                end
            end
            ACT_ST: begin
                cyc_next = '0;
                col_next = col_reg + COL_W'(1);
                if (col_reg == COL_LAST) begin
                    col_next   = '0;
                    state_next = HBLK_ST;
                end
            end
            HBLK_ST: begin
                if (cyc_reg == HBLK_LAST) begin
                    cyc_next = '0;
                    if (line_reg == ACT_LAST) begin
                        line_next  = '0;
                        state_next = VFP_ST;
                    end else begin
                        line_next  = line_reg + LINE_W'(1);
                        state_next = ACT_ST;
                    end
                end
            end
            VFP_ST: begin
                if (cyc_reg == VFP_LAST) begin
                    cyc_next   = '0;
                    state_next = cam_start ? VSYNC_ST : IDLE_ST;
                end
            end
            default: begin
                cyc_next   = '0;
                line_next  = '0;
                state_next = IDLE_ST;
            end
        endcase
    end

    always_comb begin
        state     = state_reg;
        phase     = col_reg[0];
        frame_end = (state_reg == VFP_ST) && (cyc_reg == VFP_LAST);
    end

endmodule

// File: rtl/dvp_tx_controller.sv
// DVP transmitter: takes RGB565 pixels on a valid/ready handshake and serializes
// them two bytes per pixel onto VSYNC/HREF/DATA with fixed frame timing.
module dvp_tx_controller
    import dvp_pkg::*;
#(
    parameter int DVP_DATA_W = 8,
    parameter int RGB_PXL_W  = 16,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int H_BLANK    = 144,
    parameter int VSYNC_W    = 3,
    parameter int V_BP       = 17,
    parameter int V_FP       = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cam_start_i,
    dvp_tx_controller_if.master bus,
    output logic                frame_done_o,
    output logic                underrun_o
);
    dvp_state_t state;
    logic       phase;
    logic       frame_end;
    logic       pxl_slot;

    logic [DVP_DATA_W-1:0] hi_byte, lo_byte, first_byte, second_byte;
    logic [DVP_DATA_W-1:0] data_reg, hold_reg;
    logic                  vsync_reg, href_reg, frame_done_reg, underrun_reg;

    dvp_tx_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .H_BLANK  (H_BLANK),
        .VSYNC_W  (VSYNC_W),
        .V_BP     (V_BP),
        .V_FP     (V_FP)
    ) u_timing (
        .clk       (clk),
        .rst_n     (rst_n),
        .cam_start (cam_start_i),
        .state     (state),
        .phase     (phase),
        .frame_end (frame_end)
    );

    assign pxl_slot        = (state == ACT_ST) && !phase;
    assign bus.rgb_pxl_rdy = pxl_slot;

    assign hi_byte     = bus.rgb_pxl[RGB_PXL_W-1 -: DVP_DATA_W];
    assign lo_byte     = bus.rgb_pxl[DVP_DATA_W-1:0];
    assign first_byte  = HI_BYTE_FIRST ? hi_byte : lo_byte;
    assign second_byte = HI_BYTE_FIRST ? lo_byte : hi_byte;

    // A missing pixel in its slot is sent as two zero bytes; timing never stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_reg      <= 1'b0;
            href_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            underrun_reg   <= 1'b0;
            data_reg       <= '0;
            hold_reg       <= '0;
        end else begin
            vsync_reg      <= (state == VSYNC_ST);
            href_reg       <= (state == ACT_ST);
            frame_done_reg <= frame_end;
            underrun_reg   <= pxl_slot && !bus.rgb_pxl_vld;
            if (pxl_slot) begin
                data_reg <= bus.rgb_pxl_vld ? first_byte : '0;
                hold_reg <= bus.rgb_pxl_vld ? second_byte : '0;
            end else if (state == ACT_ST) begin
                data_reg <= hold_reg;
            end else begin
                data_reg <= '0;
            end
        end
    end

    assign bus.dvp_vsync = vsync_reg;
    assign bus.dvp_href  = href_reg;
    assign bus.dvp_data  = data_reg;
    assign frame_done_o  = frame_done_reg;
    assign underrun_o    = underrun_reg;

endmodule

// File: tb/tb_dvp_tx_controller.sv
// Directed bench for dvp_tx_controller with a small frame (4x3 pixels, 1 back-porch line).
module tb_dvp_tx_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cam_start = 1'b0;
    logic frame_done, underrun;

    int n_tests = 0;
    int n_failed = 0;
    int cyc = 0;

    // capture results
    int vs_rise, vs_cnt, href_rise, n_bursts, fd_cyc, fd_seen;
    int ur_cnt, ur_idx, bad_low, hs_cnt, pix_idx, slot;
    int burst_len[8];
    bit ur_ok;
    logic [7:0] bytes_q[$];

    always #5 clk = ~clk;

    dvp_tx_controller_if #(.DVP_DATA_W(8), .RGB_PXL_W(16)) bus ();

    dvp_tx_controller #(
        .DVP_DATA_W(8), .RGB_PXL_W(16), .H_ACTIVE(4), .V_ACTIVE(3),
        .H_BLANK(2), .VSYNC_W(3), .V_BP(1), .V_FP(2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cam_start_i  (cam_start),
        .bus          (bus),
        .frame_done_o (frame_done),
        .underrun_o   (underrun)
    );

    // Pixel k has nibbles 4k+1..4k+4 (mod 16): 0x1234, 0x5678, 0x9ABC, 0xDEF0, ...
    function automatic logic [15:0] pix(input int k);
        logic [15:0] v;
        for (int j = 0; j < 4; j++) v[15-4*j -: 4] = 4'((4*k + j + 1) & 15);
        return v;
    endfunction

    function automatic logic [7:0] exp_byte(input int drop, input int b);
        int s;
        int p;
        logic [15:0] v;
        s = b / 2;
        if (drop >= 0 && s == drop) return 8'h00;
        p = (drop >= 0 && s > drop) ? s - 1 : s;
        v = pix(p);
        return (b % 2 == 0) ? v[15:8] : v[7:0];
    endfunction

    // -1 when the captured stream is the 24 expected bytes, else first bad index
    function automatic int stream_err(input int drop);
        for (int b = 0; b < 24; b++)
            if (b >= bytes_q.size() || bytes_q[b] !== exp_byte(drop, b)) return b;
        if (bytes_q.size() != 24) return 24;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic quiet_cycles(input int n, output int bad);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if ({bus.rgb_pxl_rdy, bus.dvp_vsync, bus.dvp_href, bus.dvp_data, frame_done, underrun} !== 13'd0)
                bad++;
        end
    endtask

    // Acts as the pixel source and records the bus until frame_done_o is seen.
    task automatic capture(input int drop_slot, input int stop_after, input int max_cyc);
        logic vs_prev, href_prev, rdy_pre, vld_pre;
        vs_rise = -1; href_rise = -1; vs_cnt = 0; n_bursts = 0; fd_seen = 0; fd_cyc = -1;
        ur_cnt = 0; ur_idx = -1; ur_ok = 0; bad_low = 0; hs_cnt = 0; pix_idx = 0; slot = 0;
        for (int i = 0; i < 8; i++) burst_len[i] = 0;
        bytes_q.delete();
        vs_prev = bus.dvp_vsync;
        href_prev = bus.dvp_href;
        bus.rgb_pxl = pix(0);
        bus.rgb_pxl_vld = !(bus.rgb_pxl_rdy && drop_slot == 0);
        for (int i = 1; i <= max_cyc && fd_seen == 0; i++) begin
            rdy_pre = bus.rgb_pxl_rdy;
            vld_pre = bus.rgb_pxl_vld;
            tick();
            if (rdy_pre) begin
                slot++;
                if (vld_pre) begin pix_idx++; hs_cnt++; end
            end
            if (i == stop_after) cam_start = 1'b0;
            if (bus.dvp_vsync && !vs_prev) vs_rise = cyc;
            if (bus.dvp_vsync) vs_cnt++;
            vs_prev = bus.dvp_vsync;
            if (bus.dvp_href) begin
                if (!href_prev) begin
                    if (href_rise < 0) href_rise = cyc;
                    n_bursts++;
                end
                if (n_bursts >= 1 && n_bursts <= 8) burst_len[n_bursts-1]++;
                bytes_q.push_back(bus.dvp_data);
            end else if (bus.dvp_data !== 8'h00) begin
                bad_low++;
            end
            href_prev = bus.dvp_href;
            if (underrun) begin
                ur_cnt++;
                ur_idx = bytes_q.size() - 1;
                ur_ok = (bus.dvp_href === 1'b1) && (bus.dvp_data === 8'h00);
            end
            if (frame_done) begin fd_seen = 1; fd_cyc = cyc; end
            bus.rgb_pxl = pix(pix_idx);
            bus.rgb_pxl_vld = !(bus.rgb_pxl_rdy && slot == drop_slot);
        end
        if (fd_seen == 0) begin
            n_tests++; n_failed++;
            $display("FAIL capture_timeout: frame_done_o not seen within %0d cycles", max_cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cam_start = 1'b0;
        bus.rgb_pxl = 16'hABCD; bus.rgb_pxl_vld = 1'b1;
        repeat (3) tick();
        n_tests++;
        if ({bus.rgb_pxl_rdy, bus.dvp_vsync, bus.dvp_href, bus.dvp_data, frame_done, underrun} !== 13'd0) begin
            n_failed++;
            $display("FAIL reset_outputs: rdy=%b vs=%b href=%b data=%h fd=%b ur=%b, required all 0",
                     bus.rgb_pxl_rdy, bus.dvp_vsync, bus.dvp_href, bus.dvp_data, frame_done, underrun);
        end
        rst_n = 1'b1;
        tick();
        $display("[TB] reset done");
    endtask

    task automatic test_idle();
        int bad;
        bus.rgb_pxl_vld = 1'b1;
        quiet_cycles(20, bad);
        n_tests++;
        if (bad != 0) begin n_failed++; $display("FAIL idle_quiet: %0d active cycles, required 0", bad); end
        $display("[TB] idle: %0d active cycles", bad);
    endtask

    task automatic test_single_frame();
        int bad, e;
        cam_start = 1'b1;
        capture(-1, 1, 200);
        n_tests++;
        if (vs_cnt != 3) begin n_failed++; $display("FAIL single_vsync_width: got %0d required 3", vs_cnt); end
        n_tests++;
        if (n_bursts != 3) begin n_failed++; $display("FAIL single_bursts: got %0d required 3", n_bursts); end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (burst_len[i] != 8) begin n_failed++; $display("FAIL single_href_len%0d: got %0d required 8", i, burst_len[i]); end
        end
        n_tests++;
        if (bytes_q.size() < 3 || bytes_q[0] !== 8'h12 || bytes_q[1] !== 8'h34 || bytes_q[2] !== 8'h56) begin
            n_failed++; $display("FAIL single_first_bytes: size %0d, required 12 34 56 at start", bytes_q.size());
        end
        e = stream_err(-1);
        n_tests++;
        if (e >= 0) begin n_failed++; $display("FAIL single_stream: first bad byte index %0d of %0d captured", e, bytes_q.size()); end
        n_tests++;
        if (fd_cyc - vs_rise != 44) begin n_failed++; $display("FAIL single_frame_len: frame_done at +%0d required +44", fd_cyc - vs_rise); end
        n_tests++;
        if (href_rise - vs_rise != 13) begin n_failed++; $display("FAIL single_href_start: +%0d required +13", href_rise - vs_rise); end
        n_tests++;
        if (hs_cnt != 12) begin n_failed++; $display("FAIL single_handshakes: got %0d required 12", hs_cnt); end
        n_tests++;
        if (bad_low != 0 || ur_cnt != 0) begin n_failed++; $display("FAIL single_clean: data outside href %0d, underruns %0d, required 0", bad_low, ur_cnt); end
        tick();
        n_tests++;
        if (frame_done !== 1'b0) begin n_failed++; $display("FAIL single_fd_pulse: frame_done_o still %b, required 0", frame_done); end
        quiet_cycles(15, bad);
        n_tests++;
        if (bad != 0) begin n_failed++; $display("FAIL single_back_idle: %0d active cycles, required 0", bad); end
        $display("[TB] single frame: vsync %0d, bursts %0d, handshakes %0d, frame_done +%0d", vs_cnt, n_bursts, hs_cnt, fd_cyc - vs_rise);
    endtask

    task automatic test_back_to_back();
        int first_vs, first_fd, bad;
        cam_start = 1'b1;
        capture(-1, -1, 200);
        first_vs = vs_rise; first_fd = fd_cyc;
        n_tests++;
        if (hs_cnt != 12) begin n_failed++; $display("FAIL b2b_handshakes1: got %0d required 12", hs_cnt); end
        capture(-1, 5, 200);
        n_tests++;
        if (vs_rise != first_fd + 1) begin n_failed++; $display("FAIL b2b_vsync_after_fd: vsync at %0d required %0d", vs_rise, first_fd + 1); end
        n_tests++;
        if (vs_rise - first_vs != 45) begin n_failed++; $display("FAIL b2b_period: got %0d required 45", vs_rise - first_vs); end
        n_tests++;
        if (hs_cnt != 12 || n_bursts != 3) begin n_failed++; $display("FAIL b2b_frame2: handshakes %0d bursts %0d, required 12 and 3", hs_cnt, n_bursts); end
        quiet_cycles(15, bad);
        n_tests++;
        if (bad != 0) begin n_failed++; $display("FAIL b2b_stop: %0d active cycles, required 0", bad); end
        $display("[TB] back-to-back: period %0d, handshakes %0d", vs_rise - first_vs, hs_cnt);
    endtask

    task automatic test_underrun();
        int bad, e;
        cam_start = 1'b1;
        capture(6, 1, 200);
        n_tests++;
        if (ur_cnt != 1) begin n_failed++; $display("FAIL underrun_count: got %0d required 1", ur_cnt); end
        n_tests++;
        if (ur_idx != 12 || !ur_ok) begin n_failed++; $display("FAIL underrun_position: byte index %0d ok=%b, required 12 with zero data", ur_idx, ur_ok); end
        e = stream_err(6);
        n_tests++;
        if (e >= 0) begin n_failed++; $display("FAIL underrun_stream: first bad byte index %0d of %0d captured", e, bytes_q.size()); end
        n_tests++;
        if (burst_len[0] != 8 || burst_len[1] != 8 || burst_len[2] != 8 || n_bursts != 3) begin
            n_failed++; $display("FAIL underrun_href: bursts %0d lens %0d %0d %0d, required 3 of 8", n_bursts, burst_len[0], burst_len[1], burst_len[2]);
        end
        n_tests++;
        if (fd_cyc - vs_rise != 44 || hs_cnt != 11) begin
            n_failed++; $display("FAIL underrun_timing: frame_done +%0d handshakes %0d, required +44 and 11", fd_cyc - vs_rise, hs_cnt);
        end
        quiet_cycles(5, bad);
        $display("[TB] underrun: pulses %0d at byte %0d, handshakes %0d", ur_cnt, ur_idx, hs_cnt);
    endtask

    task automatic test_stop_mid_frame();
        int bad, e;
        cam_start = 1'b1;
        capture(-1, 20, 200);
        e = stream_err(-1);
        n_tests++;
        if (n_bursts != 3 || e >= 0) begin n_failed++; $display("FAIL stop_complete: bursts %0d bad byte %0d, required 3 and none", n_bursts, e); end
        n_tests++;
        if (fd_cyc - vs_rise != 44) begin n_failed++; $display("FAIL stop_frame_len: +%0d required +44", fd_cyc - vs_rise); end
        quiet_cycles(20, bad);
        n_tests++;
        if (bad != 0) begin n_failed++; $display("FAIL stop_no_restart: %0d active cycles, required 0", bad); end
        $display("[TB] stop mid-frame: bursts %0d, then %0d active cycles", n_bursts, bad);
    endtask

    task automatic test_reset_mid_line();
        int bad, e, waited;
        bus.rgb_pxl = 16'h55AA; bus.rgb_pxl_vld = 1'b1;
        cam_start = 1'b1;
        tick();
        cam_start = 1'b0;
        waited = 0;
        while (bus.dvp_href !== 1'b1 && waited < 40) begin tick(); waited++; end
        n_tests++;
        if (bus.dvp_href !== 1'b1) begin n_failed++; $display("FAIL rst_mid_wait: href not seen in 40 cycles"); end
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        n_tests++;
        if ({bus.rgb_pxl_rdy, bus.dvp_vsync, bus.dvp_href, bus.dvp_data, frame_done, underrun} !== 13'd0) begin
            n_failed++;
            $display("FAIL rst_mid_outputs: rdy=%b vs=%b href=%b data=%h fd=%b ur=%b, required all 0",
                     bus.rgb_pxl_rdy, bus.dvp_vsync, bus.dvp_href, bus.dvp_data, frame_done, underrun);
        end
        rst_n = 1'b1;
        quiet_cycles(60, bad);
        n_tests++;
        if (bad != 0) begin n_failed++; $display("FAIL rst_mid_aborted: %0d active cycles, required 0", bad); end
        cam_start = 1'b1;
        capture(-1, 1, 200);
        e = stream_err(-1);
        n_tests++;
        if (n_bursts != 3 || e >= 0 || fd_cyc - vs_rise != 44) begin
            n_failed++; $display("FAIL rst_mid_restart: bursts %0d bad byte %0d frame_done +%0d, required 3, none, +44", n_bursts, e, fd_cyc - vs_rise);
        end
        quiet_cycles(5, bad);
        $display("[TB] reset mid-line: restart bursts %0d", n_bursts);
    endtask

    initial begin
        bus.rgb_pxl = '0;
        bus.rgb_pxl_vld = 1'b0;
        test_reset();
        test_idle();
        test_single_frame();
        test_back_to_back();
        test_underrun();
        test_stop_mid_frame();
        test_reset_mid_line();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
